tbird_light_monitor: RTL

//  Passive checker/decoder on the 6-bit tail-light bus driven by the turn-signal FSM.

---
 rtl/tbird_pkg.sv | 32 +++
 rtl/tbird_light_monitor_if.sv | 33 +++
 rtl/light_pattern_decode.sv | 25 ++
 rtl/tbird_light_monitor.sv | 88 ++++++++
 4 files changed

// File: rtl/tbird_pkg.sv
// Shared types, light-bus pattern codes and the transition legality rule for the
// tail-light bus monitor.
package tbird_pkg;

  typedef enum logic [3:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ, UNK} light_state_t;

  // y[5:3] = LC,LB,LA ; y[2:0] = RA,RB,RC
  localparam logic [5:0] PAT_IDLE = 6'b000_000;
  localparam logic [5:0] PAT_L1   = 6'b001_000;
  localparam logic [5:0] PAT_L2   = 6'b011_000;
  localparam logic [5:0] PAT_L3   = 6'b111_000;
  localparam logic [5:0] PAT_R1   = 6'b000_100;
  localparam logic [5:0] PAT_R2   = 6'b000_110;
  localparam logic [5:0] PAT_R3   = 6'b000_111;
  localparam logic [5:0] PAT_HAZ  = 6'b111_111;

  // UNK as cur is never checked; the monitor resyncs from it silently.
  function automatic logic is_legal(light_state_t cur, light_state_t nxt, logic allow_stall);
    logic ok;
    ok = allow_stall && (cur == nxt);
    case (cur)
      IDLE:    ok = ok | (nxt inside {IDLE, L1, R1, HAZ});
      L1:      ok = ok | (nxt inside {L2, IDLE});
      L2:      ok = ok | (nxt inside {L3, IDLE});
      R1:      ok = ok | (nxt inside {R2, IDLE});
      R2:      ok = ok | (nxt inside {R3, IDLE});
      default: ok = ok | (nxt == IDLE);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tbird_light_monitor_if.sv
// Light-bus monitor port bundle. Optional capture ports appear only when
// LIGHT_MON_CAPTURE_EN is defined.
interface tbird_light_monitor_if #(parameter int CNT_W = 8);
  logic [5:0]       y;
  logic             clear_err;
  logic             left_active;
  logic             right_active;
  logic             hazard;
  logic [1:0]       phase;
  logic             err_pulse;
  logic             seq_error;
  logic [CNT_W-1:0] err_count;
`ifdef LIGHT_MON_CAPTURE_EN
  logic [5:0]       bad_prev;
  logic [5:0]       bad_cur;
`endif

  modport master (
    output y, clear_err,
`ifdef LIGHT_MON_CAPTURE_EN
    input  bad_prev, bad_cur,
`endif
    input  left_active, right_active, hazard, phase, err_pulse, seq_error, err_count
  );

  modport slave (
    input  y, clear_err,
`ifdef LIGHT_MON_CAPTURE_EN
    output bad_prev, bad_cur,
`endif
    output left_active, right_active, hazard, phase, err_pulse, seq_error, err_count
  );
endinterface

// File: rtl/light_pattern_decode.sv
// Combinational decode of the 6-bit light bus into a monitor state; unknown codes
// map to UNK with known=0.
module light_pattern_decode
  import tbird_pkg::*;
(
  input  logic [5:0]   y,
  output light_state_t state,
  output logic         known
);
  always_comb begin
    state = UNK;
    known = 1'b1;
    case (y)
      PAT_IDLE: state = IDLE;
      PAT_L1:   state = L1;
      PAT_L2:   state = L2;
      PAT_L3:   state = L3;
      PAT_R1:   state = R1;
      PAT_R2:   state = R2;
      PAT_R3:   state = R3;
      PAT_HAZ:  state = HAZ;
      default:  known = 1'b0;
    endcase
  end
endmodule

// File: rtl/tbird_light_monitor.sv
// Passive tail-light bus checker: tracks the turn-signal sequence, flags illegal
// transitions. Define LIGHT_MON_CAPTURE_EN to latch the offending y pair.
module tbird_light_monitor
  import tbird_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit ALLOW_STALL = 1'b0
)(
  input logic                  clk,
  input logic                  reset,
  tbird_light_monitor_if.slave bus
);
  light_state_t     st_q, st_d, dec_st;
  logic             known, err;
  logic             err_q, seq_q;
  logic [CNT_W-1:0] cnt_q;

  light_pattern_decode u_dec (.y(bus.y), .state(dec_st), .known(known));

  // State always follows the decoded bus, so an error is followed by a resync.
  always_comb begin
    st_d = dec_st;
    err  = 1'b0;
    if (st_q != UNK)
      err = !known || !is_legal(st_q, dec_st, ALLOW_STALL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= IDLE;
      err_q <= 1'b0;
      seq_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      err_q <= err;
      // An error in the same cycle as clear_err wins and restarts the count at 1.
      if (err) begin
        seq_q <= 1'b1;
        cnt_q <= bus.clear_err ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
      end else if (bus.clear_err) begin
        seq_q <= 1'b0;
        cnt_q <= '0;
      end
    end
  end

`ifdef LIGHT_MON_CAPTURE_EN
  logic [5:0] y_q, bprev_q, bcur_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q     <= '0;
      bprev_q <= '0;
      bcur_q  <= '0;
    end else begin
      y_q <= bus.y;
      if (err) begin
        bprev_q <= y_q;
        bcur_q  <= bus.y;
      end else if (bus.clear_err) begin
        bprev_q <= '0;
        bcur_q  <= '0;
      end
    end
  end

  assign bus.bad_prev = bprev_q;
  assign bus.bad_cur  = bcur_q;
`endif

  assign bus.left_active  = st_q inside {L1, L2, L3};
  assign bus.right_active = st_q inside {R1, R2, R3};
  assign bus.hazard       = (st_q == HAZ);
  assign bus.err_pulse    = err_q;
  assign bus.seq_error    = seq_q;
  assign bus.err_count    = cnt_q;

  always_comb begin
    bus.phase = 2'd0;
    case (st_q)
      L1, R1:      bus.phase = 2'd1;
      L2, R2:      bus.phase = 2'd2;
      L3, R3, HAZ: bus.phase = 2'd3;
      default:     bus.phase = 2'd0;
    endcase
  end
endmodule
